// File: rtl/modmul_issue_if.sv
// Operand handshake, reducer valid-only link and result stream of the Barrett issue front end.
interface modmul_issue_if;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] red_din;
   logic        red_din_valid;
   logic [31:0] red_dout;
   logic        red_dout_valid;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [2:0]  err;

   modport slave (
      input  in_a, in_b, in_valid, red_dout, red_dout_valid, out_ready,
      output in_ready, red_din, red_din_valid, out_data, out_valid, busy, err
   );

   modport master (
      output in_a, in_b, in_valid, red_dout, red_dout_valid, out_ready,
      input  in_ready, red_din, red_din_valid, out_data, out_valid, busy, err
   );
endinterface

// File: rtl/modmul_issue.sv
// Two-stage 32x32 product pipeline feeding a non-stallable Barrett reducer,
// with credit admission so every reducer result has a guaranteed FIFO slot.
module modmul_issue #(
   parameter logic [31:0] PARAM_MOD  = 32'd4294966657,
   parameter int          RED_LAT    = 13,
   parameter int          FIFO_DEPTH = 16
) (
   input logic           clk,
   input logic           rst_b,
   modmul_issue_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(RED_LAT + 3);
   localparam logic [GW-1:0] GUARD_INIT = GW'(RED_LAT + 2);

   logic [CW-1:0] inflight;
   logic [CW-1:0] count;
   logic [CW:0]   credit_used;
   logic [GW-1:0] guard;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [31:0]   head;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [63:0]   prod_q;
   logic [2:1]    vld_pipe;
   logic [2:0]    err_q;
   logic          accept;
   logic          ret;
   logic          full;
   logic          wr;
   logic          rd;

   // Each accepted pair holds one credit from accept until its result leaves the FIFO.
   assign credit_used  = {1'b0, inflight} + {1'b0, count};
   assign bus.in_ready = (credit_used < (CW+1)'(FIFO_DEPTH)) && !rst_b && (guard == '0);
   assign accept       = bus.in_valid && bus.in_ready;
   assign ret          = bus.red_dout_valid && (inflight != '0);
   assign full         = (count == CW'(FIFO_DEPTH));
   assign rd           = bus.out_valid && bus.out_ready;
   assign wr           = ret && (!full || rd);

   always_ff @(posedge clk) begin
      if (rst_b) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], accept};
         if (accept) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
         end
         if (vld_pipe[1]) prod_q <= 64'(a_q) * 64'(b_q);
      end
   end

   // Guard outlasts the reducer pipe, so results issued before reset drain silently.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         inflight <= '0;
         guard    <= GUARD_INIT;
         err_q    <= '0;
      end else begin
         if (accept && !ret)      inflight <= inflight + CW'(1);
         else if (!accept && ret) inflight <= inflight - CW'(1);
         if (guard != '0) guard <= guard - GW'(1);
         if (bus.red_dout_valid && full && !rd) err_q[0] <= 1'b1;
         if (bus.red_dout_valid && inflight == '0 && guard == '0) err_q[1] <= 1'b1;
         if (accept && (bus.in_a >= PARAM_MOD || bus.in_b >= PARAM_MOD)) err_q[2] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= bus.red_dout;
   end

   // head mirrors mem[rptr] so out_data comes straight from a register.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         head  <= '0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) rptr <= rptr + AW'(1);
         count <= count + CW'(wr) - CW'(rd);
         if (wr && (count == '0 || (count == CW'(1) && rd))) head <= bus.red_dout;
         else if (rd)                                          head <= mem[rptr + AW'(1)];
      end
   end

   assign bus.red_din       = prod_q;
   assign bus.red_din_valid = vld_pipe[2];
   assign bus.out_data      = head;
   assign bus.out_valid     = (count != '0);
   assign bus.busy          = (inflight != '0) || (count != '0);
   assign bus.err           = err_q;
endmodule

// File: tb/tb_modmul_issue.sv
// Directed bench for modmul_issue paired with a latency-13 behavioural Barrett reducer.
module tb_modmul_issue;
   localparam logic [31:0] Q       = 32'd4294966657;
   localparam int          RED_LAT = 13;

   logic clk;
   logic rst_b;
   logic inj;
   int   checks;
   int   errors;
   int   acc;
   int   wt;
   int   wt2;
   logic [31:0] sa;
   logic [31:0] sb;
   logic [63:0] sq[$];
   logic [63:0] bq[$];

   modmul_issue_if bus_if();

   modmul_issue #(.PARAM_MOD(Q), .RED_LAT(RED_LAT), .FIFO_DEPTH(16)) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus_if.slave)
   );

   // Reducer model: not reset, so stale results still emerge after an rst_b pulse.
   logic [RED_LAT-1:0] rv = '0;
   logic [31:0]        rdat [RED_LAT];
   always @(posedge clk) begin
      rv      <= {rv[RED_LAT-2:0], bus_if.red_din_valid};
      rdat[0] <= 32'(bus_if.red_din % 64'(Q));
      for (int i = 1; i < RED_LAT; i++) rdat[i] <= rdat[i-1];
   end
   assign bus_if.red_dout_valid = rv[RED_LAT-1] | inj;
   assign bus_if.red_dout       = rv[RED_LAT-1] ? rdat[RED_LAT-1] : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, required $finish before 200us");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      bus_if.in_a     = a;
      bus_if.in_b     = b;
      bus_if.in_valid = 1'b1;
      chk("issue_ready", 64'(bus_if.in_ready), 64'd1);
      step(1);
      bus_if.in_valid = 1'b0;
   endtask

   // Waits (bounded) for a result, checks it, and lets out_ready pop it.
   task automatic expect_out(input string tag, input logic [63:0] exp);
      int n;
      n = 0;
      while (!bus_if.out_valid && n < 40) begin
         step(1);
         n++;
      end
      chk({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
      chk(tag, 64'(bus_if.out_data), exp);
      step(1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      inj    = 1'b0;
      rst_b  = 1'b1;
      bus_if.in_a      = '0;
      bus_if.in_b      = '0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      step(3);
      chk("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("rst_red_din", bus_if.red_din, 64'd0);
      chk("rst_red_din_valid", 64'(bus_if.red_din_valid), 64'd0);
      chk("rst_out_data", 64'(bus_if.out_data), 64'd0);
      chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("rst_busy", 64'(bus_if.busy), 64'd0);
      chk("rst_err", 64'(bus_if.err), 64'd0);

      // Guard: in_ready first rises on the 15th edge after reset release.
      rst_b = 1'b0;
      step(14);
      chk("guard_ready_lo", 64'(bus_if.in_ready), 64'd0);
      step(1);
      chk("guard_ready_hi", 64'(bus_if.in_ready), 64'd1);

      // Single op 3*5
      issue(32'd3, 32'd5);
      step(1);
      chk("single_red_din_valid", 64'(bus_if.red_din_valid), 64'd1);
      chk("single_red_din", bus_if.red_din, 64'd15);
      step(1);
      chk("single_red_din_pulse", 64'(bus_if.red_din_valid), 64'd0);
      step(12);
      chk("single_early", 64'(bus_if.out_valid), 64'd0);
      step(1);
      chk("single_valid", 64'(bus_if.out_valid), 64'd1);
      chk("single_data", 64'(bus_if.out_data), 64'd15);
      bus_if.out_ready = 1'b1;
      step(1);
      chk("single_out_valid_after", 64'(bus_if.out_valid), 64'd0);
      chk("single_busy", 64'(bus_if.busy), 64'd0);

      // Corner values
      issue(Q - 32'd1, Q - 32'd1);
      issue(32'h8000_0000, 32'd2);
      issue(32'd0, Q - 32'd1);
      expect_out("corner_qm1_sq", 64'd1);
      expect_out("corner_2p32", 64'd639);
      expect_out("corner_zero", 64'd0);
      chk("corner_err", 64'(bus_if.err), 64'd0);

      // Second accept lands on the edge the first result is written.
      issue(32'd11, 32'd13);
      step(14);
      issue(32'd17, 32'd19);
      expect_out("simul_first", 64'd143);
      expect_out("simul_second", 64'd323);
      chk("simul_busy", 64'(bus_if.busy), 64'd0);
      chk("simul_err", 64'(bus_if.err), 64'd0);

      // Stream of 100 random in-range pairs with out_ready held high
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               sa = $urandom % Q;
               sb = $urandom % Q;
               bus_if.in_a     = sa;
               bus_if.in_b     = sb;
               bus_if.in_valid = 1'b1;
               wt = 0;
               while (!bus_if.in_ready && wt < 50) begin
                  step(1);
                  wt++;
               end
               if (wt == 50) chk("stream_stall", 64'(bus_if.in_ready), 64'd1);
               sq.push_back(64'(sa) * 64'(sb) % 64'(Q));
               step(1);
            end
            bus_if.in_valid = 1'b0;
         end
         begin
            for (int j = 0; j < 100; j++) begin
               wt2 = 0;
               while (!bus_if.out_valid && wt2 < 60) begin
                  step(1);
                  wt2++;
               end
               if (wt2 == 60) begin
                  chk("stream_timeout", 64'(bus_if.out_valid), 64'd1);
                  break;
               end
               chk("stream_data", 64'(bus_if.out_data), sq.pop_front());
               step(1);
            end
         end
      join
      step(2);
      chk("stream_err", 64'(bus_if.err), 64'd0);
      chk("stream_busy", 64'(bus_if.busy), 64'd0);

      // Backpressure: credits cap accepts at the FIFO depth
      bus_if.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 60; c++) begin
         bus_if.in_a     = 32'(1000 + acc);
         bus_if.in_b     = 32'd77;
         bus_if.in_valid = 1'b1;
         if (bus_if.in_ready) begin
            bq.push_back(64'(1000 + acc) * 64'd77);
            acc++;
         end
         step(1);
      end
      chk("bp_accepts", 64'(acc), 64'd16);
      chk("bp_ready_lo", 64'(bus_if.in_ready), 64'd0);
      chk("bp_held", 64'(bus_if.out_valid), 64'd1);
      chk("bp_head", 64'(bus_if.out_data), bq.pop_front());
      bus_if.out_ready = 1'b1;
      step(1);
      bus_if.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         bus_if.in_a = 32'(2000 + acc);
         if (bus_if.in_ready) begin
            bq.push_back(64'(2000 + acc) * 64'd77);
            acc++;
         end
         step(1);
      end
      chk("bp_one_more", 64'(acc), 64'd1);
      chk("bp_err", 64'(bus_if.err), 64'd0);
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) expect_out("bp_drain", bq.pop_front());
      chk("bp_busy", 64'(bus_if.busy), 64'd0);

      // Reset pulse with 8 pairs in the reducer
      for (int k = 0; k < 8; k++) issue(32'(k + 5), 32'd9);
      step(3);
      rst_b = 1'b1;
      step(1);
      chk("midrst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("midrst_red_din", bus_if.red_din, 64'd0);
      chk("midrst_red_din_valid", 64'(bus_if.red_din_valid), 64'd0);
      chk("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("midrst_out_data", 64'(bus_if.out_data), 64'd0);
      chk("midrst_busy", 64'(bus_if.busy), 64'd0);
      rst_b = 1'b0;
      step(14);
      chk("midrst_guard_lo", 64'(bus_if.in_ready), 64'd0);
      step(1);
      chk("midrst_guard_hi", 64'(bus_if.in_ready), 64'd1);
      chk("midrst_err", 64'(bus_if.err), 64'd0);
      chk("midrst_no_stale", 64'(bus_if.out_valid), 64'd0);

      // Spurious return after the guard
      inj = 1'b1;
      step(1);
      inj = 1'b0;
      chk("spurious_err", 64'(bus_if.err), 64'd2);
      chk("spurious_dropped", 64'(bus_if.out_valid), 64'd0);

      // Out-of-range operand still processed
      issue(Q, 32'd1);
      chk("range_err", 64'(bus_if.err), 64'd6);
      expect_out("range_data", 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
